alu_sequencer: RTL

Multi-cycle controller that sequences the shared ALU datapath for one operation at a time. It accepts an operation request over a valid/ready handshake and drives the external Y-register load. It then presents the operand on the bus with the ALU control code, captures the 2×REG_SIZE Z result, and returns lo/hi result words over a second valid/ready handshake. It sits between instruction control and the ALU/Y/Z datapath. It also screens illegal opcodes, divide-by-zero and out-of-range shift/rotate amounts before the ALU sees them.

---
 rtl/alu_seq_pkg.sv | 17 +
 rtl/alu_seq_decode.sv | 20 ++
 rtl/alu_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU code map, sequencer state encoding and default word width shared by the sequencer and the ALU.
package alu_seq_pkg;
  localparam int REG_SIZE_DEF = 32;
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h3;
  localparam logic [3:0] ALU_SHR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_ROR = 4'h6;
  localparam logic [3:0] ALU_ROL = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'h8;
  localparam logic [3:0] ALU_DIV = 4'h9;
  localparam logic [3:0] ALU_NEG = 4'hA;
  localparam logic [3:0] ALU_NOT = 4'hB;
  typedef enum logic [1:0] {S_IDLE, S_LOAD_Y, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: screens an incoming request's opcode and operand before it reaches the ALU.
module alu_seq_decode import alu_seq_pkg::*; #(
  parameter int REG_SIZE = REG_SIZE_DEF
) (
  input  logic [3:0]          i_op,
  input  logic [REG_SIZE-1:0] i_b,
  output logic                o_illegal,
  output logic                o_div0,
  output logic                o_is_shift,
  output logic                o_rot_zero,
  output logic                o_hi_valid
);
  logic w_rot;
  assign w_rot      = (i_op == ALU_ROR) || (i_op == ALU_ROL);
  assign o_illegal  = i_op > ALU_NOT;
  assign o_div0     = (i_op == ALU_DIV) && (i_b == '0);
  assign o_is_shift = (i_op == ALU_SHR) || (i_op == ALU_SHL) || w_rot;
  assign o_rot_zero = w_rot && (i_b[4:0] == 5'd0);
  assign o_hi_valid = i_op == ALU_MUL;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one ALU operation at a time through Y load, execute and a held response.
module alu_sequencer import alu_seq_pkg::*; #(
  parameter int REG_SIZE = REG_SIZE_DEF
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [REG_SIZE-1:0]   req_a,
  input  logic [REG_SIZE-1:0]   req_b,
  output logic                  y_load,
  output logic [REG_SIZE-1:0]   y_data,
  output logic [3:0]            alu_ctrl,
  output logic [REG_SIZE-1:0]   bus_data,
  input  logic [2*REG_SIZE-1:0] z_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_SIZE-1:0]   rsp_lo,
  output logic [REG_SIZE-1:0]   rsp_hi,
  output logic                  rsp_err,
  output logic [15:0]           op_count
);
  state_t              r_state;
  logic [3:0]          r_op;
  logic [REG_SIZE-1:0] r_a, r_b, r_lo, r_hi;
  logic                r_err, r_shift, r_hiv;
  logic [15:0]         r_count;
  logic                w_illegal, w_div0, w_is_shift, w_rot_zero, w_hi_valid;
  logic [REG_SIZE-1:0] w_bus;
  alu_seq_decode #(.REG_SIZE(REG_SIZE)) u_decode (
    .i_op       (req_op),
    .i_b        (req_b),
    .o_illegal  (w_illegal),
    .o_div0     (w_div0),
    .o_is_shift (w_is_shift),
    .o_rot_zero (w_rot_zero),
    .o_hi_valid (w_hi_valid)
  );
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_err   <= 1'b0;
      r_shift <= 1'b0;
      r_hiv   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_op    <= req_op;
          r_a     <= req_a;
          r_b     <= req_b;
          r_shift <= w_is_shift;
          r_hiv   <= w_hi_valid;
          r_err   <= w_illegal || w_div0;
          r_lo    <= w_rot_zero ? req_a : '0;
          r_hi    <= '0;
          r_state <= (w_illegal || w_div0 || w_rot_zero) ? S_RESP : S_LOAD_Y;
        end
        S_LOAD_Y: r_state <= S_EXEC;
        S_EXEC: begin
          r_lo    <= z_in[REG_SIZE-1:0];
          r_hi    <= r_hiv ? z_in[2*REG_SIZE-1:REG_SIZE] : '0;
          r_state <= S_RESP;
        end
        default: if (rsp_ready) begin
          r_state <= S_IDLE;
          if (!r_err && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        end
      endcase
    end
  // Shift and rotate amounts reach the ALU already reduced mod 32.
  assign w_bus     = r_shift ? {{(REG_SIZE-5){1'b0}}, r_b[4:0]} : r_b;
  assign req_ready = r_state == S_IDLE;
  assign y_load    = r_state == S_LOAD_Y;
  assign y_data    = y_load ? r_a : '0;
  assign alu_ctrl  = (r_state == S_EXEC) ? r_op : 4'h0;
  assign bus_data  = (r_state == S_EXEC) ? w_bus : '0;
  assign rsp_valid = r_state == S_RESP;
  assign rsp_lo    = rsp_valid ? r_lo : '0;
  assign rsp_hi    = rsp_valid ? r_hi : '0;
  assign rsp_err   = rsp_valid && r_err;
  assign op_count  = r_count;
endmodule
